iir_cascade_sched: RTL and testbench

Time-multiplexed controller that runs a cascade of SECTIONS second-order IIR sections on one shared signed multiplier and accumulator. It sequences the five coefficient products of each section and holds per-section z1/z2 state and a writable coefficient bank. It accepts samples through a valid/ready handshake and presents one filtered sample per input. Each section's results are bit-exact with the team's standalone direct-form-II biquad section chained SECTIONS times.

---
 rtl/iir_cascade_sched.sv | 181 ++++++++++++++++++
 tb/tb_iir_cascade_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_cascade_sched.sv
// Cascade of second-order DF-II IIR sections time-multiplexed onto one shared
// multiplier/accumulator; five MAC cycles per section, per-section z state and coefficients.
module iir_cascade_sched #(
  parameter int unsigned SECTIONS = 4,
  parameter int unsigned bitwidth = 32,
  parameter int unsigned fac      = 20,
  parameter int unsigned gain     = 4,
  localparam int unsigned SEC_W   = (SECTIONS > 1) ? $clog2(SECTIONS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bitwidth-1:0] x,
  output logic                out_valid,
  output logic [bitwidth-1:0] y,
  input  logic                cfg_we,
  input  logic [SEC_W-1:0]    cfg_sec,
  input  logic [2:0]          cfg_idx,
  input  logic [bitwidth-1:0] cfg_data,
  output logic                cfg_err
);

  localparam int unsigned ACC_W = 2 * bitwidth;
  localparam logic [bitwidth-1:0] UNITY = bitwidth'(1) << fac;

  typedef enum logic [2:0] {IDLE, A1, A2, B0, B1, B2} state_t;

  state_t state, state_next;

  logic [SEC_W-1:0]           sec;
  logic signed [bitwidth-1:0] u;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    w1;
  logic signed [ACC_W-1:0]    z1 [SECTIONS];
  logic signed [ACC_W-1:0]    z2 [SECTIONS];
  logic signed [bitwidth-1:0] cb0 [SECTIONS];
  logic signed [bitwidth-1:0] cb1 [SECTIONS];
  logic signed [bitwidth-1:0] cb2 [SECTIONS];
  logic signed [bitwidth-1:0] ca1 [SECTIONS];
  logic signed [bitwidth-1:0] ca2 [SECTIONS];

  logic                       accept;
  logic                       last_sec;
  logic                       sec_ok;
  logic                       cfg_take;
  logic signed [bitwidth-1:0] mul_coef;
  logic signed [ACC_W-1:0]    mul_op;
  logic signed [ACC_W-1:0]    prod;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    w_shift;
  logic signed [bitwidth-1:0] sec_out;

  assign last_sec = (sec == SEC_W'(SECTIONS - 1));
  assign sec_ok   = (32'(cfg_sec) < SECTIONS);
  assign cfg_take = cfg_we && (state == IDLE) && sec_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and multiplier operand selection
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mul_coef   = '0;
    mul_op     = '0;
    case (state)
      IDLE: begin
        accept = in_valid;
        if (in_valid) state_next = A1;
      end
      A1: begin
        mul_coef   = ca1[sec];
        mul_op     = z1[sec];
        state_next = A2;
      end
      A2: begin
        mul_coef   = ca2[sec];
        mul_op     = z2[sec];
        state_next = B0;
      end
      B0: begin
        mul_coef   = cb0[sec];
        mul_op     = w1;
        state_next = B1;
      end
      B1: begin
        mul_coef   = cb1[sec];
        mul_op     = z1[sec];
        state_next = B2;
      end
      B2: begin
        mul_coef   = cb2[sec];
        mul_op     = z2[sec];
        state_next = last_sec ? IDLE : A1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shared MAC; everything wraps modulo 2^(2*bitwidth)
  always_comb begin
    prod = ACC_W'(mul_coef) * mul_op;
    case (state)
      A1:      acc_next = (ACC_W'(u) <<< fac) - prod;
      A2:      acc_next = acc - prod;
      B0:      acc_next = prod;
      B1, B2:  acc_next = acc + prod;
      default: acc_next = acc;
    endcase
    w_shift = acc_next >>> fac;
    sec_out = bitwidth'(w_shift >>> gain);
  end

  // Datapath, coefficient bank and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sec       <= '0;
      u         <= '0;
      acc       <= '0;
      w1        <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      cfg_err   <= 1'b0;
      for (int i = 0; i < int'(SECTIONS); i++) begin
        z1[i]  <= '0;
        z2[i]  <= '0;
        cb0[i] <= UNITY;
        cb1[i] <= '0;
        cb2[i] <= '0;
        ca1[i] <= '0;
        ca2[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      in_ready  <= (state_next == IDLE);
      cfg_err   <= cfg_we && ((state != IDLE) || !sec_ok);
      if (cfg_take) begin
        case (cfg_idx)
          3'd0:    cb0[cfg_sec] <= cfg_data;
          3'd1:    cb1[cfg_sec] <= cfg_data;
          3'd2:    cb2[cfg_sec] <= cfg_data;
          3'd3:    ca1[cfg_sec] <= cfg_data;
          3'd4:    ca2[cfg_sec] <= cfg_data;
          default: ;
        endcase
      end
      case (state)
        IDLE: begin
          if (accept) begin
            u   <= x;
            sec <= '0;
          end
        end
        A1, B0, B1: acc <= acc_next;
        A2: begin
          acc <= acc_next;
          w1  <= w_shift;
        end
        B2: begin
          acc      <= acc_next;
          z2[sec]  <= z1[sec];
          z1[sec]  <= w1;
          if (last_sec) begin
            y         <= sec_out;
            out_valid <= 1'b1;
          end else begin
            u   <= sec_out;
            sec <= sec + SEC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_cascade_sched.sv
// Self-checking bench: cycle-level behavioural model of the cascade (counter + chained biquad
// arithmetic on longint) compared every cycle, plus hand-computed literal cases.
module tb_iir_cascade_sched;

  localparam int SEC  = 4;
  localparam int BW   = 32;
  localparam int FAC  = 20;
  localparam int GAIN = 4;
  localparam int LAT  = 5 * SEC + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] x;
  logic          out_valid;
  logic [BW-1:0] y;
  logic          cfg_we;
  logic [1:0]    cfg_sec;
  logic [2:0]    cfg_idx;
  logic [BW-1:0] cfg_data;
  logic          cfg_err;

  // Second instance with 3 sections so an out-of-range cfg_sec is representable
  logic          in_ready3, out_valid3, cfg_err3, cfg_we3;
  logic [BW-1:0] y3;
  logic [1:0]    cfg_sec3;

  iir_cascade_sched #(.SECTIONS(SEC), .bitwidth(BW), .fac(FAC), .gain(GAIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .y(y), .cfg_we(cfg_we), .cfg_sec(cfg_sec),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_err(cfg_err));

  iir_cascade_sched #(.SECTIONS(3), .bitwidth(BW), .fac(FAC), .gain(GAIN)) dut3 (
    .clk(clk), .rst(rst), .in_valid(1'b0), .in_ready(in_ready3), .x('0),
    .out_valid(out_valid3), .y(y3), .cfg_we(cfg_we3), .cfg_sec(cfg_sec3),
    .cfg_idx(3'd0), .cfg_data('0), .cfg_err(cfg_err3));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model state
  int     mc [SEC][5];   // b0, b1, b2, a1, a2
  longint mz1 [SEC];
  longint mz2 [SEC];
  int     m_busy, m_pend, m_y;
  bit     m_ready, m_valid, m_err;

  function automatic void model_reset();
    for (int s = 0; s < SEC; s++) begin
      mz1[s] = 0;
      mz2[s] = 0;
      mc[s][0] = 1 << FAC;
      for (int i = 1; i < 5; i++) mc[s][i] = 0;
    end
    m_busy = 0; m_pend = 0; m_y = 0;
    m_ready = 1'b1; m_valid = 1'b0; m_err = 1'b0;
  endfunction

  // Chain of standalone DF-II biquads, 64-bit wrapping arithmetic
  function automatic int model_step(input int xin);
    longint acc, w1, w2;
    int uu = xin;
    for (int s = 0; s < SEC; s++) begin
      acc = (longint'(uu) <<< FAC) - longint'(mc[s][3]) * mz1[s] - longint'(mc[s][4]) * mz2[s];
      w1  = acc >>> FAC;
      acc = longint'(mc[s][0]) * w1 + longint'(mc[s][1]) * mz1[s] + longint'(mc[s][2]) * mz2[s];
      w2  = acc >>> FAC;
      mz2[s] = mz1[s];
      mz1[s] = w1;
      uu = int'(w2 >>> GAIN);
    end
    return uu;
  endfunction

  // Compare process: check registered outputs, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready", longint'(in_ready), longint'(m_ready));
      check("out_valid", longint'(out_valid), longint'(m_valid));
      check("cfg_err", longint'(cfg_err), longint'(m_err));
      check("y", longint'($signed(y)), longint'(m_y));
    end
    if (rst) begin
      model_reset();
    end else begin
      m_err = cfg_we && (m_busy != 0 || int'(cfg_sec) >= SEC);
      if (cfg_we && m_busy == 0 && int'(cfg_sec) < SEC && cfg_idx < 3'd5)
        mc[cfg_sec][cfg_idx] = $signed(cfg_data);
      m_valid = 1'b0;
      if (m_busy == 0) begin
        if (in_valid) begin
          m_pend = model_step($signed(x));
          m_busy = 5 * SEC;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1'b1;
          m_y = m_pend;
        end
      end
      m_ready = (m_busy == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for an out_valid pulse; returns negedges waited, 0 on timeout
  task automatic wait_out(output int lat, output int yv);
    lat = 0;
    yv = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        yv = $signed(y);
        break;
      end
    end
  endtask

  task automatic send_sample(input int xv, output int lat, output int yv);
    in_valid = 1'b1;
    x = xv;
    tick();
    in_valid = 1'b0;
    wait_out(lat, yv);
    tick();
  endtask

  function automatic int rnd_coef();
    return int'($urandom_range(0, 1 << FAC)) - (1 << (FAC - 1));
  endfunction

  int lat, yv, acc_n, pulses, low;
  int acc_cyc [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0;
    cfg_we = 1'b0; cfg_sec = '0; cfg_idx = '0; cfg_data = '0;
    cfg_we3 = 1'b0; cfg_sec3 = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_y", longint'($signed(y)), 0);
    check("rst_cfg_err", longint'(cfg_err), 0);
    tick();

    // Default pass-through: 65536 >> 16 = 1, exact latency
    send_sample(65536, lat, yv);
    check("lat_default", lat, LAT);
    check("y_default_pos", yv, 1);
    check("model_default_pos", m_y, 1);
    send_sample(-65536, lat, yv);
    check("y_default_neg", yv, -1);

    // Back-to-back acceptance with in_valid held high
    in_valid = 1'b1;
    x = 1 << 20;
    acc_n = 0; pulses = 0; low = 0;
    for (int k = 0; k < 200 && acc_n < 3; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
      if (in_ready) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
        if (acc_n == 3) begin
          @(posedge clk);
          #2;
          in_valid = 1'b0;
        end
      end else begin
        low++;
      end
    end
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    tick();
    check("tp_accepts", acc_n, 3);
    check("tp_gap1", acc_cyc[1] - acc_cyc[0], LAT);
    check("tp_gap2", acc_cyc[2] - acc_cyc[1], LAT);
    check("tp_ready_low", low, 2 * (LAT - 1));
    check("tp_pulses", pulses, 3);
    check("tp_y", longint'($signed(y)), 16);

    // Write while busy is dropped and flagged the following cycle
    in_valid = 1'b1; x = 65536;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    cfg_we = 1'b1; cfg_sec = 2'd0; cfg_idx = 3'd0; cfg_data = '0;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    check("busy_cfg_err", longint'(cfg_err), 1);
    wait_out(lat, yv);
    tick();
    check("busy_cfg_y", yv, 1);

    // Write in the acceptance cycle is used by that sample: last section gain x2
    in_valid = 1'b1; x = 65536;
    cfg_we = 1'b1; cfg_sec = 2'd3; cfg_idx = 3'd0; cfg_data = 2 << FAC;
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    wait_out(lat, yv);
    tick();
    check("same_cycle_cfg_y", yv, 2);

    // Abort mid-computation
    in_valid = 1'b1; x = 65536;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", longint'(in_ready), 1);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    tick();
    check("abort_no_pulse", pulses, 0);
    send_sample(65536, lat, yv);
    check("abort_next_lat", lat, LAT);
    check("abort_next_y", yv, 1);

    // Integrator in section 0
    do_reset();
    cfg_we = 1'b1; cfg_sec = 2'd0; cfg_idx = 3'd3; cfg_data = -(1 << FAC);
    tick();
    cfg_we = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      send_sample(65536, lat, yv);
      check("integrator_y", yv, n);
      check("integrator_model", m_y, n);
    end

    // Out-of-range section on the 3-section instance
    cfg_we3 = 1'b1; cfg_sec3 = 2'd3;
    tick();
    cfg_we3 = 1'b0;
    @(negedge clk);
    check("sec_range_err", longint'(cfg_err3), 1);
    tick();
    cfg_we3 = 1'b1; cfg_sec3 = 2'd2;
    tick();
    cfg_we3 = 1'b0;
    @(negedge clk);
    check("sec_inrange_err", longint'(cfg_err3), 0);
    tick();

    // Random coefficients and samples, including dropped and ignored writes
    do_reset();
    for (int s = 0; s < SEC; s++) begin
      for (int i = 0; i < 5; i++) begin
        cfg_we = 1'b1; cfg_sec = 2'(s); cfg_idx = 3'(i); cfg_data = rnd_coef();
        tick();
      end
    end
    cfg_we = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      in_valid = 1'b1;
      x = int'($urandom_range(0, 1 << 24)) - (1 << 23);
      if ($urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1;
        cfg_sec = 2'($urandom_range(0, 3));
        cfg_idx = 3'($urandom_range(0, 7));
        cfg_data = rnd_coef();
      end
      tick();
      in_valid = 1'b0;
      cfg_we = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 15)) tick();
        cfg_we = 1'b1;
        cfg_sec = 2'($urandom_range(0, 3));
        cfg_idx = 3'($urandom_range(0, 7));
        cfg_data = rnd_coef();
        tick();
        cfg_we = 1'b0;
      end
      wait_out(lat, yv);
      check("rand_out_seen", longint'(lat != 0), 1);
      tick();
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
